// File: rtl/mux_4x1_4bit_rr.sv
// Round-robin 4:1 merge of 4-bit valid/ready channels onto one registered output.
// The output word is tagged with the 2-bit index of the source channel it came from.
module mux_4x1_4bit_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [3:0] in_valid,
    output logic [3:0] in_ready,
    output logic [3:0] out,
    output logic [1:0] out_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] xfer_cnt
);

    logic [1:0] ptr;
    logic       can_load;
    logic [7:0] vld_rot;
    logic       grant_vld;
    logic [1:0] grant_off;
    logic [1:0] grant_idx;
    logic [3:0] grant_data;
    logic       load;

    // Rotate in_valid so bit 0 is the channel at ptr; the lowest set bit wins.
    always_comb begin
        can_load  = !out_valid || out_ready;
        vld_rot   = {in_valid, in_valid} >> ptr;
        grant_vld = 1'b0;
        grant_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (vld_rot[i]) begin
                grant_vld = 1'b1;
                grant_off = 2'(i);
            end
        end
        grant_idx = ptr + grant_off;
        in_ready  = 4'b0000;
        if (grant_vld && can_load && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
        case (grant_idx)
            2'd0:    grant_data = a;
            2'd1:    grant_data = b;
            2'd2:    grant_data = c;
            default: grant_data = d;
        endcase
        load = |in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= 4'd0;
            out_sel   <= 2'd0;
            out_valid <= 1'b0;
            ptr       <= 2'd0;
            xfer_cnt  <= 8'd0;
        end else if (load) begin
            out       <= grant_data;
            out_sel   <= grant_idx;
            out_valid <= 1'b1;
            ptr       <= grant_idx + 2'd1;
            xfer_cnt  <= xfer_cnt + 8'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_4x1_4bit_rr.sv
// Self-checking bench for mux_4x1_4bit_rr: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_mux_4x1_4bit_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0, b = '0, c = '0, d = '0;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [3:0] out;
    logic [1:0] out_sel;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] xfer_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int         m_ptr = 0;
    logic [3:0] m_out = '0;
    logic [1:0] m_sel = '0;
    logic       m_valid = 1'b0;
    int         m_cnt = 0;

    mux_4x1_4bit_rr dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] chan_data(int ch);
        case (ch)
            0: return a;
            1: return b;
            2: return c;
            default: return d;
        endcase
    endfunction

    // Channel granted this cycle, or -1 when nothing is accepted.
    function automatic int m_grant();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < 4; k++) begin
            int ch;
            ch = (m_ptr + k) % 4;
            if (in_valid[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock; model follows the inputs present at the edge.
    task automatic tick();
        int g;
        logic [3:0] gd;
        g  = m_grant();
        gd = (g >= 0) ? chan_data(g) : 4'd0;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_out = '0; m_sel = '0; m_valid = 1'b0; m_cnt = 0;
        end else if (g >= 0) begin
            m_out = gd; m_sel = 2'(g); m_valid = 1'b1;
            m_ptr = (g + 1) % 4; m_cnt = (m_cnt + 1) % 256;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL reset_in_ready cyc%0d got=%b exp=0000", i, in_ready);
            end
            tick();
            n_cmp++;
            if ({out_valid, out_sel, out, xfer_cnt} !== 15'd0) begin
                n_err++;
                $display("FAIL reset_state cyc%0d got v=%b sel=%0d out=%h cnt=%0d exp all 0",
                         i, out_valid, out_sel, out, xfer_cnt);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({out_valid, out_sel, out} !== {1'b1, 2'(i % 4), 4'(i % 4 + 1)}) begin
                n_err++;
                $display("FAIL rr_seq i=%0d got v=%b sel=%0d out=%h exp v=1 sel=%0d out=%0d",
                         i, out_valid, out_sel, out, i % 4, i % 4 + 1);
            end
        end
        n_cmp++;
        if (xfer_cnt !== 8'd8) begin
            n_err++; $display("FAIL rr_count got=%0d exp=8", xfer_cnt);
        end
    endtask

    task automatic test_pointer_skip();
        do_reset();
        a = 4'h7; b = 4'h9; c = 4'h3; d = 4'hE; out_ready = 1'b1;
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b0001;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL skip_wrap_ready got=%b exp=0001", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_sel, out} !== {2'd0, 4'h7}) begin
            n_err++; $display("FAIL skip_wrap_out got sel=%0d out=%h exp sel=0 out=7", out_sel, out);
        end
        in_valid = 4'b1010;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++; $display("FAIL skip_b_before_d got=%b exp=0010", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_sel, out} !== {2'd1, 4'h9}) begin
            n_err++; $display("FAIL skip_b_out got sel=%0d out=%h exp sel=1 out=9", out_sel, out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a = 4'h1; b = 4'h2; c = 4'hA; d = 4'h5; out_ready = 1'b1;
        in_valid = 4'b0100;
        tick();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready cyc%0d got=%b exp=0000", i, in_ready);
            end
            tick();
            n_cmp++;
            if ({out_valid, out_sel, out} !== {1'b1, 2'd2, 4'hA}) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d got v=%b sel=%0d out=%h exp v=1 sel=2 out=a",
                         i, out_valid, out_sel, out);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b1000) begin
            n_err++; $display("FAIL bp_release_ready got=%b exp=1000", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_sel, out} !== {1'b1, 2'd3, 4'h5}) begin
            n_err++;
            $display("FAIL bp_release_out got v=%b sel=%0d out=%h exp v=1 sel=3 out=5",
                     out_valid, out_sel, out);
        end
    endtask

    task automatic test_drain();
        in_valid = 4'b0000; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({out_valid, out_sel, out} !== {1'b0, 2'd3, 4'h5}) begin
                n_err++;
                $display("FAIL drain cyc%0d got v=%b sel=%0d out=%h exp v=0 sel=3 out=5",
                         i, out_valid, out_sel, out);
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 255) begin
                n_cmp++;
                if (xfer_cnt !== 8'd255) begin
                    n_err++; $display("FAIL wrap_255 got=%0d exp=255", xfer_cnt);
                end
            end
        end
        n_cmp++;
        if (xfer_cnt !== 8'd0) begin
            n_err++; $display("FAIL wrap_256 got=%0d exp=0", xfer_cnt);
        end
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, out_sel, out, xfer_cnt} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_mid_stall got v=%b sel=%0d out=%h cnt=%0d exp all 0",
                     out_valid, out_sel, out, xfer_cnt);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int bad_rdy, bad_out;
        bad_rdy = 0; bad_out = 0;
        for (int i = 0; i < 3000; i++) begin
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            #1;
            n_cmp++;
            if (in_ready !== m_ready()) begin
                n_err++;
                if (bad_rdy++ < 10)
                    $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, m_ready());
            end
            tick();
            n_cmp++;
            if ({out_valid, out_sel, out, xfer_cnt} !== {m_valid, m_sel, m_out, 8'(m_cnt)}) begin
                n_err++;
                if (bad_out++ < 10)
                    $display("FAIL rand_out i=%0d got v=%b sel=%0d out=%h cnt=%0d exp v=%b sel=%0d out=%h cnt=%0d",
                             i, out_valid, out_sel, out, xfer_cnt, m_valid, m_sel, m_out, m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pointer_skip();
        test_backpressure();
        test_drain();
        test_counter_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
